// File: rtl/rc4_ksa_param.sv
// RC4 key-scheduling engine: 256-step shuffle of an external 256x8 S memory with a configurable key length and read latency.
// Define RC4_KSA_INIT_FILL_EN to add a built-in S[i]=i fill phase ahead of the shuffle.
module rc4_ksa_param #(
    parameter int KEY_BYTES = 3,
    parameter int RD_LAT    = 2
) (
    input  logic                   inclk,
    input  logic                   reset_n,
    input  logic                   start,
    input  logic                   abort,
    input  logic [KEY_BYTES*8-1:0] secret_key,
    output logic [7:0]             mem_addr,
    output logic [7:0]             mem_wdata,
    output logic                   mem_wren,
    input  logic [7:0]             mem_q,
    output logic                   busy,
    output logic                   done
);

    localparam int          KEY_W    = KEY_BYTES * 8;
    localparam int          KIDX_W   = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

    typedef enum logic [3:0] {
        S_IDLE,
`ifdef RC4_KSA_INIT_FILL_EN
        S_FILL,
`endif
        S_RD_I,
        S_WAIT_I,
        S_CALC_J,
        S_RD_J,
        S_WAIT_J,
        S_WR_J,
        S_WR_I,
        S_NEXT,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [7:0]          i_q, i_d;
    logic [7:0]          j_q, j_d;
    logic [KIDX_W-1:0]   kidx_q, kidx_d;
    logic [1:0]          cnt_q, cnt_d;
    logic [7:0]          si_q, si_d;
    logic [7:0]          sj_q, sj_d;
    logic [KEY_W-1:0]    key_q, key_d;
    logic [7:0]          addr_d, wdata_d;
    logic                wren_d;
    logic [7:0]          key_byte;

    // Key byte 0 sits in the most significant byte of the latched key.
    always_comb begin
        key_byte = '0;
        for (int k = 0; k < KEY_BYTES; k++) begin
            if (kidx_q == KIDX_W'(k))
                key_byte = key_q[KEY_W-1-8*k -: 8];
        end
    end

    always_comb begin
        // NOTE: every target gets a default first, so no branch leaves one unassigned and infers a latch.
        state_d = state_q;
        i_d     = i_q;
        j_d     = j_q;
        kidx_d  = kidx_q;
        cnt_d   = cnt_q;
        si_d    = si_q;
        sj_d    = sj_q;
        key_d   = key_q;
        addr_d  = mem_addr;
        wdata_d = mem_wdata;
        wren_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    key_d  = secret_key;
                    i_d    = '0;
                    j_d    = '0;
                    kidx_d = '0;
`ifdef RC4_KSA_INIT_FILL_EN
                    state_d = S_FILL;
                    addr_d  = '0;
                    wdata_d = '0;
                    wren_d  = 1'b1;
`else
                    state_d = S_RD_I;
`endif
                end
            end
`ifdef RC4_KSA_INIT_FILL_EN
            S_FILL: begin
                if (i_q == 8'hFF) begin
                    i_d     = '0;
                    state_d = S_RD_I;
                end else begin
                    i_d     = i_q + 8'd1;
                    addr_d  = i_q + 8'd1;
                    wdata_d = i_q + 8'd1;
                    wren_d  = 1'b1;
                end
            end
`endif
            S_RD_I: begin
                addr_d  = i_q;
                cnt_d   = '0;
                state_d = S_WAIT_I;
            end
            S_WAIT_I: begin
                if (cnt_q == LAT_LAST) begin
                    si_d    = mem_q;
                    state_d = S_CALC_J;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_CALC_J: begin
                j_d     = j_q + si_q + key_byte;
                state_d = S_RD_J;
            end
            S_RD_J: begin
                addr_d  = j_q;
                cnt_d   = '0;
                state_d = S_WAIT_J;
            end
            S_WAIT_J: begin
                if (cnt_q == LAT_LAST) begin
                    // Outputs are registered, so the S[j] write is launched as WR_J is entered.
                    sj_d    = mem_q;
                    addr_d  = j_q;
                    wdata_d = si_q;
                    wren_d  = 1'b1;
                    state_d = S_WR_J;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_WR_J: begin
                addr_d  = i_q;
                wdata_d = sj_q;
                wren_d  = 1'b1;
                state_d = S_WR_I;
            end
            S_WR_I: begin
                state_d = S_NEXT;
            end
            S_NEXT: begin
                if (i_q == 8'hFF) begin
                    state_d = S_DONE;
                end else begin
                    i_d     = i_q + 8'd1;
                    kidx_d  = (kidx_q == KIDX_W'(KEY_BYTES - 1)) ? '0 : kidx_q + KIDX_W'(1);
                    state_d = S_RD_I;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            wren_d  = 1'b0;
        end
    end

    always_ff @(posedge inclk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            i_q       <= '0;
            j_q       <= '0;
            kidx_q    <= '0;
            cnt_q     <= '0;
            si_q      <= '0;
            sj_q      <= '0;
            key_q     <= '0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wren  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let every register see pre-edge values, matching flop behaviour.
            state_q   <= state_d;
            i_q       <= i_d;
            j_q       <= j_d;
            kidx_q    <= kidx_d;
            cnt_q     <= cnt_d;
            si_q      <= si_d;
            sj_q      <= sj_d;
            key_q     <= key_d;
            mem_addr  <= addr_d;
            mem_wdata <= wdata_d;
            mem_wren  <= wren_d;
            busy      <= (state_d != S_IDLE);
            done      <= (state_d == S_DONE);
        end
    end

endmodule

// File: tb/tb_rc4_ksa_param.sv
// Bench for rc4_ksa_param: several parameter sets, each with its own S-memory model, checked against an RC4 KSA reference.
// Honours RC4_KSA_INIT_FILL_EN the same way as the design.
module tb_rc4_ksa_param;

    localparam int NCFG = 5;
`ifdef RC4_KSA_INIT_FILL_EN
    localparam int FILL_EN = 1;
`else
    localparam int FILL_EN = 0;
`endif

    function automatic int kb_of(input int g);
        case (g)
            0:       return 3;
            1:       return 1;
            2:       return 5;
            3:       return 16;
            default: return 32;
        endcase
    endfunction

    function automatic int rl_of(input int g);
        case (g)
            0:       return 2;
            1:       return 1;
            2:       return 3;
            3:       return 1;
            default: return 4;
        endcase
    endfunction

    logic                      clk = 1'b0;
    logic                      reset_n;
    logic                      abort;
    logic [255:0]              key_bus;
    logic [NCFG-1:0]           start_v;
    logic [NCFG-1:0]           fill_req;
    logic [NCFG-1:0]           wren_v, busy_v, done_v;
    logic [NCFG-1:0][7:0]      addr_v, wdata_v, q_v;

    logic [7:0] smem [NCFG][256];
    logic [7:0] pipe [NCFG][4];

    int total = 0;
    int bad   = 0;

    int wa[$], wd[$], wc[$];
    int exp_wa[$], exp_wd[$], exp_wc[$];
    int exp_s[256];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NCFG; g++) begin : g_dut
        localparam int KB = kb_of(g);
        localparam int RL = rl_of(g);
        rc4_ksa_param #(.KEY_BYTES(KB), .RD_LAT(RL)) u_dut (
            .inclk      (clk),
            .reset_n    (reset_n),
            .start      (start_v[g]),
            .abort      (abort),
            .secret_key (key_bus[KB*8-1:0]),
            .mem_addr   (addr_v[g]),
            .mem_wdata  (wdata_v[g]),
            .mem_wren   (wren_v[g]),
            .mem_q      (q_v[g]),
            .busy       (busy_v[g]),
            .done       (done_v[g])
        );
    end

    // S memories: write port plus a read path that delivers S[addr] exactly RD_LAT edges after addr changes.
    always @(posedge clk) begin
        for (int g = 0; g < NCFG; g++) begin
            for (int p = 3; p > 0; p--) pipe[g][p] <= pipe[g][p-1];
            pipe[g][0] <= smem[g][addr_v[g]];
            if (fill_req[g]) begin
                for (int a = 0; a < 256; a++) smem[g][a] <= (FILL_EN != 0) ? 8'(a ^ 8'h5A) : 8'(a);
            end else if (wren_v[g]) begin
                smem[g][addr_v[g]] <= wdata_v[g];
            end
        end
    end

    always_comb begin
        q_v = '0;
        for (int g = 0; g < NCFG; g++) begin
            if (rl_of(g) == 1) q_v[g] = smem[g][addr_v[g]];
            else               q_v[g] = pipe[g][rl_of(g)-2];
        end
    end

    task automatic check(input string tag, input longint obs, input longint exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference RC4 KSA on an identity S, also producing the expected write trace with cycle stamps.
    task automatic build_model(input logic [255:0] key, input int kb, input int rl);
        int s[256];
        int j, si, sj, n, base;
        exp_wa.delete(); exp_wd.delete(); exp_wc.delete();
        for (int k = 0; k < 256; k++) s[k] = k;
        n    = 6 + 2 * rl;
        base = FILL_EN * 256;
        if (FILL_EN != 0)
            for (int k = 0; k < 256; k++) begin
                exp_wa.push_back(k); exp_wd.push_back(k); exp_wc.push_back(k);
            end
        j = 0;
        for (int i = 0; i < 256; i++) begin
            j  = (j + s[i] + int'(key[(kb - 1 - (i % kb)) * 8 +: 8])) % 256;
            si = s[i];
            sj = s[j];
            exp_wa.push_back(j); exp_wd.push_back(si); exp_wc.push_back(base + i * n + 2 * rl + 3);
            exp_wa.push_back(i); exp_wd.push_back(sj); exp_wc.push_back(base + i * n + 2 * rl + 4);
            s[i] = sj;
            s[j] = si;
        end
        for (int k = 0; k < 256; k++) exp_s[k] = s[k];
    endtask

    task automatic prefill(input int k);
        fill_req[k] = 1'b1;
        @(negedge clk);
        fill_req[k] = 1'b0;
    endtask

    task automatic random_key();
        for (int w = 0; w < 8; w++) key_bus[w*32 +: 32] = $urandom;
    endtask

    // Pulse (or hold) start and log every write with its cycle index until done or the budget runs out.
    task automatic run_and_log(input int k, input bit hold, output int done_cyc);
        int budget;
        budget = FILL_EN * 256 + 256 * (6 + 2 * rl_of(k)) + 64;
        wa.delete(); wd.delete(); wc.delete();
        start_v[k] = 1'b1;
        @(negedge clk);
        if (!hold) start_v[k] = 1'b0;
        check("busy_rise", busy_v[k], 1);
        done_cyc = -1;
        for (int c = 0; c < budget; c++) begin
            if (wren_v[k]) begin
                wa.push_back(int'(addr_v[k])); wd.push_back(int'(wdata_v[k])); wc.push_back(c);
            end
            if (done_v[k]) begin
                done_cyc = c;
                break;
            end
            @(negedge clk);
        end
        start_v[k] = 1'b0;
        if (done_cyc < 0) check("done_timeout", 0, 1);
    endtask

    task automatic verify(input int k, input logic [255:0] key, input int done_cyc, input string name);
        int bad_w, bad_s, m;
        build_model(key, kb_of(k), rl_of(k));
        check({name, "_done_cycle"}, done_cyc, FILL_EN * 256 + 256 * (6 + 2 * rl_of(k)));
        check({name, "_nwrites"}, wa.size(), exp_wa.size());
        m = (wa.size() < exp_wa.size()) ? wa.size() : exp_wa.size();
        bad_w = 0;
        for (int e = 0; e < m; e++)
            if (wa[e] != exp_wa[e] || wd[e] != exp_wd[e] || wc[e] != exp_wc[e]) bad_w++;
        check({name, "_write_trace_errs"}, bad_w, 0);
        bad_s = 0;
        for (int a = 0; a < 256; a++)
            if (int'(smem[k][a]) != exp_s[a]) bad_s++;
        check({name, "_final_s_errs"}, bad_s, 0);
        @(negedge clk);
        check({name, "_busy_after_done"}, busy_v[k], 0);
        check({name, "_done_one_cycle"}, done_v[k], 0);
    endtask

    initial begin
        int dc, base, viol, c;
        bit prev_w, hit;
        logic [255:0] key;

        reset_n  = 1'b0;
        abort    = 1'b0;
        start_v  = '0;
        fill_req = '0;
        key_bus  = '0;
        #12;
        for (int k = 0; k < NCFG; k++) begin
            check("rst_wren", wren_v[k], 0);
            check("rst_busy", busy_v[k], 0);
            check("rst_done", done_v[k], 0);
        end
        check("rst_addr", addr_v[0], 0);
        check("rst_wdata", wdata_v[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);

        // All-zero key: fill trace and the first iterations are known by hand.
        key = '0; key_bus = key;
        prefill(0);
        run_and_log(0, 1'b0, dc);
        base = FILL_EN * 256;
        if (wa.size() >= base + 6) begin
            check("it0_wj_addr", wa[base],   0); check("it0_wj_data", wd[base],   0);
            check("it0_wi_addr", wa[base+1], 0); check("it0_wi_data", wd[base+1], 0);
            check("it2_wj_addr", wa[base+4], 3); check("it2_wj_data", wd[base+4], 2);
            check("it2_wi_addr", wa[base+5], 2); check("it2_wi_data", wd[base+5], 3);
        end else begin
            check("early_writes_present", wa.size(), base + 6);
        end
`ifdef RC4_KSA_INIT_FILL_EN
        viol = 0;
        for (int e = 0; e < 256 && e < wa.size(); e++)
            if (wa[e] != e || wd[e] != e || wc[e] != e) viol++;
        check("fill_trace_errs", viol, 0);
`endif
        verify(0, key, dc, "zero_key");

        // Reference key 0x010203 with start held high through the whole run.
        key = 256'h010203; key_bus = key;
        prefill(0);
        run_and_log(0, 1'b1, dc);
        verify(0, key, dc, "key010203_held_start");

        for (int r = 0; r < 2; r++) begin
            random_key(); key = key_bus;
            prefill(0);
            run_and_log(0, 1'b0, dc);
            verify(0, key, dc, "rand_cfg0");
        end

        for (int k = 1; k < NCFG; k++) begin
            random_key(); key = key_bus;
            prefill(k);
            run_and_log(k, 1'b0, dc);
            verify(k, key, dc, $sformatf("sweep_kb%0d_rl%0d", kb_of(k), rl_of(k)));
        end

        // Abort inside iteration 100, then a clean restart.
        random_key();
        prefill(0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (FILL_EN * 256 + 100 * 10 + 3) @(negedge clk);
        check("busy_before_abort", busy_v[0], 1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", busy_v[0], 0);
        check("abort_wren", wren_v[0], 0);
        viol = 0;
        for (int n = 0; n < 40; n++) begin
            if (wren_v[0] || done_v[0] || busy_v[0]) viol++;
            @(negedge clk);
        end
        check("abort_quiet_violations", viol, 0);
        random_key(); key = key_bus;
        prefill(0);
        run_and_log(0, 1'b0, dc);
        verify(0, key, dc, "after_abort");

        // Asynchronous reset while the S[j] write is on the bus.
        random_key();
        prefill(0);
        start_v[0] = 1'b1;
        @(negedge clk);
        start_v[0] = 1'b0;
        prev_w = 1'b0;
        hit    = 1'b0;
        c      = 0;
        while (!hit && c < 2000) begin
            if (c > FILL_EN * 256 + 10 && wren_v[0] && !prev_w) hit = 1'b1;
            else begin
                prev_w = wren_v[0];
                @(negedge clk);
                c++;
            end
        end
        check("found_wr_j", hit, 1);
        #1;
        reset_n = 1'b0;
        #1;
        check("midrst_wren", wren_v[0], 0);
        check("midrst_addr", addr_v[0], 0);
        check("midrst_wdata", wdata_v[0], 0);
        check("midrst_busy", busy_v[0], 0);
        check("midrst_done", done_v[0], 0);
        @(negedge clk);
        reset_n = 1'b1;
        viol = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (wren_v[0] || busy_v[0] || done_v[0]) viol++;
        end
        check("post_reset_quiet_violations", viol, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
